// File: rtl/axi_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_mem_slave
// Brief    : AXI4 memory responder backed by a word-addressed RAM. Independent
//            read and write FSMs serve single-beat and INCR/FIXED bursts with
//            byte strobes and ID echo. WRAP bursts complete with SLVERR.
// Revision : 1.0 - initial release
// ============================================================================
module axi_mem_slave #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_MEM_DEPTH_LOG2   = 12
) (
  input  logic                            CCLK,
  input  logic                            CRST,
  // Write address channel
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWLOCK,
  input  logic [3:0]                      S_AXI_AWCACHE,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic [3:0]                      S_AXI_AWQOS,
  input  logic                            S_AXI_AWUSER,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  // Write data channel
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WUSER,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  // Write response channel
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BUSER,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  // Read address channel
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [2:0]                      S_AXI_ARSIZE,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic                            S_AXI_ARLOCK,
  input  logic [3:0]                      S_AXI_ARCACHE,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic [3:0]                      S_AXI_ARQOS,
  input  logic                            S_AXI_ARUSER,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  // Read data channel
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RUSER,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int                        DEPTH       = 1 << C_MEM_DEPTH_LOG2;
  localparam int                        NBYTES      = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0]                BURST_INCR  = 2'b01;
  localparam logic [1:0]                BURST_WRAP  = 2'b10;
  localparam logic [1:0]                RESP_OKAY   = 2'b00;
  localparam logic [1:0]                RESP_SLVERR = 2'b10;
  localparam logic [C_MEM_DEPTH_LOG2-1:0] ADDR_ONE  = 1;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} rstate_t;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [DEPTH];

  wstate_t                       wstate, wstate_nxt;
  rstate_t                       rstate, rstate_nxt;
  logic [C_S_AXI_ID_WIDTH-1:0]   wid, rid;
  logic [C_MEM_DEPTH_LOG2-1:0]   waddr, raddr;
  logic [7:0]                    wlen, wbeat, rlen, rbeat;
  logic [1:0]                    wburst, rburst;
  logic                          werr;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic                          rlast_q;
  logic [1:0]                    rresp_q;
  logic                          aw_hs, w_hs, b_hs, ar_hs, r_hs, w_final;
  logic                          unused_inputs;

  // Sideband and ignored address bits have no effect on behaviour
  assign unused_inputs = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_AWSIZE, S_AXI_ARSIZE,
                           S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS,
                           S_AXI_AWUSER, S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT,
                           S_AXI_ARQOS, S_AXI_ARUSER, S_AXI_WUSER};

  // Channel outputs are forced low while reset is held
  assign S_AXI_AWREADY = !CRST && (wstate == W_IDLE);
  assign S_AXI_WREADY  = !CRST && (wstate == W_DATA);
  assign S_AXI_BVALID  = !CRST && (wstate == W_RESP);
  assign S_AXI_BID     = CRST ? '0 : wid;
  assign S_AXI_BRESP   = (S_AXI_BVALID && (werr || wburst == BURST_WRAP)) ? RESP_SLVERR : RESP_OKAY;
  assign S_AXI_BUSER   = 1'b0;
  assign S_AXI_ARREADY = !CRST && (rstate == R_IDLE);
  assign S_AXI_RVALID  = !CRST && (rstate == R_DATA);
  assign S_AXI_RID     = CRST ? '0 : rid;
  assign S_AXI_RDATA   = CRST ? '0 : rdata_q;
  assign S_AXI_RRESP   = CRST ? RESP_OKAY : rresp_q;
  assign S_AXI_RLAST   = S_AXI_RVALID && rlast_q;
  assign S_AXI_RUSER   = 1'b0;

  assign aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs    = S_AXI_WVALID && S_AXI_WREADY;
  assign b_hs    = S_AXI_BVALID && S_AXI_BREADY;
  assign ar_hs   = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_hs    = S_AXI_RVALID && S_AXI_RREADY;
  // Burst length comes from AWLEN only; WLAST is merely cross-checked
  assign w_final = (wbeat == wlen);

  // State registers for both channel FSMs
  always_ff @(posedge CCLK) begin
    if (CRST) begin
      wstate <= W_IDLE;
      rstate <= R_IDLE;
    end else begin
      wstate <= wstate_nxt;
      rstate <= rstate_nxt;
    end
  end

  // Write FSM next-state logic
  always_comb begin
    wstate_nxt = wstate;
    case (wstate)
      W_IDLE:  if (aw_hs) wstate_nxt = W_DATA;
      W_DATA:  if (w_hs && w_final) wstate_nxt = W_RESP;
      W_RESP:  if (b_hs) wstate_nxt = W_IDLE;
      default: wstate_nxt = W_IDLE;
    endcase
  end

  // Read FSM next-state logic; each beat costs one fetch cycle plus one data cycle
  always_comb begin
    rstate_nxt = rstate;
    case (rstate)
      R_IDLE:  if (ar_hs) rstate_nxt = R_FETCH;
      R_FETCH: rstate_nxt = R_DATA;
      R_DATA:  if (r_hs) rstate_nxt = rlast_q ? R_IDLE : R_FETCH;
      default: rstate_nxt = R_IDLE;
    endcase
  end

  // Write burst context: address, beat count and protocol error flag
  always_ff @(posedge CCLK) begin
    if (CRST) begin
      wid    <= '0;
      waddr  <= '0;
      wlen   <= '0;
      wburst <= '0;
      wbeat  <= '0;
      werr   <= 1'b0;
    end else if (aw_hs) begin
      wid    <= S_AXI_AWID;
      waddr  <= S_AXI_AWADDR[C_MEM_DEPTH_LOG2+1:2];
      wlen   <= S_AXI_AWLEN;
      wburst <= S_AXI_AWBURST;
      wbeat  <= '0;
      werr   <= 1'b0;
    end else if (w_hs) begin
      wbeat <= wbeat + 8'd1;
      if (wburst == BURST_INCR) waddr <= waddr + ADDR_ONE;
      if (S_AXI_WLAST != w_final) werr <= 1'b1;
    end
  end

  // Byte-strobed RAM write; WRAP bursts are drained without touching memory
  always_ff @(posedge CCLK) begin
    if (w_hs && wburst != BURST_WRAP) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (S_AXI_WSTRB[b]) mem[waddr][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  // Read burst context and registered data beat
  always_ff @(posedge CCLK) begin
    if (CRST) begin
      rid     <= '0;
      raddr   <= '0;
      rlen    <= '0;
      rburst  <= '0;
      rbeat   <= '0;
      rdata_q <= '0;
      rlast_q <= 1'b0;
      rresp_q <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        rid    <= S_AXI_ARID;
        raddr  <= S_AXI_ARADDR[C_MEM_DEPTH_LOG2+1:2];
        rlen   <= S_AXI_ARLEN;
        rburst <= S_AXI_ARBURST;
        rbeat  <= '0;
      end else if (r_hs) begin
        rbeat <= rbeat + 8'd1;
        if (rburst == BURST_INCR) raddr <= raddr + ADDR_ONE;
      end
      if (rstate == R_FETCH) begin
        rdata_q <= (rburst == BURST_WRAP) ? '0 : mem[raddr];
        rlast_q <= (rbeat == rlen);
        rresp_q <= (rburst == BURST_WRAP) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_mem_slave
// Brief    : Self-checking bench for axi_mem_slave: directed scenarios plus
//            randomized bursts against a word-array memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_mem_slave;

  logic        clk, rst;
  logic        awid, awlock, awuser, awvalid, awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst;
  logic [3:0]  awcache, awqos;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wuser, wvalid, wready;
  logic        bid, buser, bvalid, bready;
  logic [1:0]  bresp;
  logic        arid, arlock, aruser, arvalid, arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst;
  logic [3:0]  arcache, arqos;
  logic        rid, rlast, ruser, rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  int total = 0;
  int bad   = 0;

  logic [31:0] model_mem   [4096];
  bit          model_known [4096];
  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];

  axi_mem_slave dut (
    .CCLK(clk), .CRST(rst),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
    .S_AXI_AWBURST(awburst), .S_AXI_AWLOCK(awlock), .S_AXI_AWCACHE(awcache),
    .S_AXI_AWPROT(awprot), .S_AXI_AWQOS(awqos), .S_AXI_AWUSER(awuser),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WUSER(wuser),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BUSER(buser), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize),
    .S_AXI_ARBURST(arburst), .S_AXI_ARLOCK(arlock), .S_AXI_ARCACHE(arcache),
    .S_AXI_ARPROT(arprot), .S_AXI_ARQOS(arqos), .S_AXI_ARUSER(aruser),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RUSER(ruser), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Word index touched by beat i of a burst
  function automatic logic [11:0] beat_idx(input logic [11:0] base, input int i,
                                           input logic [1:0] burst);
    return (burst == 2'b01) ? base + 12'(i) : base;
  endfunction

  function automatic void model_write(input logic [11:0] a, input logic [31:0] d,
                                      input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) model_mem[a][8*b +: 8] = d[8*b +: 8];
    model_known[a] = model_known[a] || (s == 4'hF);
  endfunction

  task automatic send_aw(input logic id, input logic [11:0] idx, input logic [7:0] len,
                         input logic [1:0] burst);
    int t = 0;
    @(negedge clk);
    awid = id; awaddr = {18'($urandom), idx, 2'($urandom)}; awlen = len;
    awburst = burst; awsize = 3'($urandom); awcache = 4'($urandom); awvalid = 1'b1;
    while (!awready && t < 50) begin @(negedge clk); t++; end
    if (!awready) check("aw_timeout", 0, 1);
    @(posedge clk); #1 awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic last);
    int t = 0;
    @(negedge clk);
    wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
    while (!wready && t < 50) begin @(negedge clk); t++; end
    if (!wready) check("w_timeout", 0, 1);
    @(posedge clk); #1 wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic id, input logic [11:0] idx, input logic [7:0] len,
                         input logic [1:0] burst);
    int t = 0;
    @(negedge clk);
    arid = id; araddr = {18'($urandom), idx, 2'($urandom)}; arlen = len;
    arburst = burst; arsize = 3'($urandom); arprot = 3'($urandom); arvalid = 1'b1;
    while (!arready && t < 50) begin @(negedge clk); t++; end
    if (!arready) check("ar_timeout", 0, 1);
    @(posedge clk); #1 arvalid = 1'b0;
  endtask

  // Full write transaction; err_beat flips WLAST on that beat (-1 for none)
  task automatic axi_write(input logic id, input logic [11:0] idx, input logic [7:0] len,
                           input logic [1:0] burst, input int err_beat, input int bstall);
    logic exp_err, last;
    int   t = 0;
    exp_err = (burst == 2'b10);
    send_aw(id, idx, len, burst);
    @(negedge clk); check("wready_after_aw", wready, 1);
    for (int i = 0; i <= int'(len); i++) begin
      last = (i == int'(len));
      if (i == err_beat) begin last = !last; exp_err = 1'b1; end
      send_w(wbuf[i], sbuf[i], last);
      if (burst != 2'b10) model_write(beat_idx(idx, i, burst), wbuf[i], sbuf[i]);
    end
    @(negedge clk); check("bvalid_after_last_w", bvalid, 1);
    while (!bvalid && t < 50) begin @(negedge clk); t++; end
    check("bid", bid, id);
    check("bresp", bresp, exp_err ? 2'b10 : 2'b00);
    for (int k = 0; k < bstall; k++) begin
      @(negedge clk);
      check("bvalid_hold", bvalid, 1);
      check("bid_hold", bid, id);
      check("awready_blocked", awready, 0);
    end
    bready = 1'b1; @(posedge clk); #1 bready = 1'b0;
    @(negedge clk); check("awready_after_b", awready, 1);
  endtask

  // Full read transaction with random RREADY stalls of up to stall_max cycles
  task automatic axi_read(input logic id, input logic [11:0] idx, input logic [7:0] len,
                          input logic [1:0] burst, input int stall_max);
    logic [31:0] ed;
    logic [1:0]  er;
    bit          dk;
    int          st;
    send_ar(id, idx, len, burst);
    @(negedge clk); check("rvalid_in_fetch", rvalid, 0);
    for (int i = 0; i <= int'(len); i++) begin
      if (burst == 2'b10) begin ed = 0; er = 2'b10; dk = 1; end
      else begin
        ed = model_mem[beat_idx(idx, i, burst)]; er = 2'b00;
        dk = model_known[beat_idx(idx, i, burst)];
      end
      @(negedge clk);
      check("rvalid_latency", rvalid, 1);
      if (dk) check("rdata", rdata, ed);
      check("rlast", rlast, i == int'(len));
      check("rresp", rresp, er);
      check("rid", rid, id);
      st = $urandom_range(0, stall_max);
      for (int k = 0; k < st; k++) begin
        @(negedge clk);
        check("rvalid_stall", rvalid, 1);
        if (dk) check("rdata_stall", rdata, ed);
        check("rlast_stall", rlast, i == int'(len));
      end
      rready = 1'b1; @(posedge clk); #1 rready = 1'b0;
      if (i != int'(len)) begin @(negedge clk); check("rvalid_gap", rvalid, 0); end
    end
    @(negedge clk); check("arready_after_r", arready, 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] idx;
    logic [7:0]  len;
    logic [1:0]  burst;
    int          r;
    clk = 0; rst = 1;
    {awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awuser, awvalid} = '0;
    {wdata, wstrb, wlast, wuser, wvalid, bready} = '0;
    {arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid} = '0;
    rready = 0;
    for (int i = 0; i < 4096; i++) model_known[i] = 0;

    repeat (3) @(negedge clk);
    check("rst_awready", awready, 0); check("rst_arready", arready, 0);
    check("rst_wready", wready, 0);   check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);   check("rst_rlast", rlast, 0);
    check("rst_zero_fields", {bresp, rresp, bid, rid, rdata}, 0);
    rst = 0; #1;
    check("idle_awready", awready, 1); check("idle_arready", arready, 1);

    // Single write and readback
    wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
    axi_write(1'b1, 12'h004, 8'd0, 2'b01, -1, 0);
    axi_read(1'b1, 12'h004, 8'd0, 2'b01, 0);
    check("single_const", model_mem[12'h004], 32'hDEADBEEF);

    // INCR burst 1..4 at 0x100
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
    axi_write(1'b0, 12'h040, 8'd3, 2'b01, -1, 0);
    axi_read(1'b0, 12'h040, 8'd3, 2'b01, 0);

    // Byte strobes
    wbuf[0] = 32'hFFFFFFFF; sbuf[0] = 4'hF;
    axi_write(1'b0, 12'h050, 8'd0, 2'b01, -1, 0);
    wbuf[0] = 32'hAAAA5555; sbuf[0] = 4'b0011;
    axi_write(1'b0, 12'h050, 8'd0, 2'b01, -1, 0);
    check("strobe_model", model_mem[12'h050], 32'hFFFF5555);
    axi_read(1'b1, 12'h050, 8'd0, 2'b01, 0);

    // FIXED burst of 3 to 0x20: last beat wins
    for (int i = 0; i < 3; i++) begin wbuf[i] = 32'hC0DE0000 + 32'(i); sbuf[i] = 4'hF; end
    axi_write(1'b1, 12'h008, 8'd2, 2'b00, -1, 0);
    axi_read(1'b1, 12'h008, 8'd0, 2'b01, 0);

    // Backpressure on B and R
    wbuf[0] = 32'h12345678; sbuf[0] = 4'hF;
    axi_write(1'b1, 12'h060, 8'd0, 2'b01, -1, 5);
    axi_read(1'b0, 12'h040, 8'd3, 2'b01, 4);

    // WRAP write leaves RAM untouched; WRAP read returns zero with SLVERR
    wbuf[0] = 32'h0BADF00D; wbuf[1] = 32'h0BADF00D; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
    axi_write(1'b1, 12'h004, 8'd1, 2'b10, -1, 0);
    axi_read(1'b1, 12'h004, 8'd0, 2'b01, 0);
    axi_read(1'b0, 12'h004, 8'd2, 2'b10, 1);

    // Early WLAST on beat 1 of 4: all beats accepted, SLVERR
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hE0000000 + 32'(i); sbuf[i] = 4'hF; end
    axi_write(1'b0, 12'h070, 8'd3, 2'b01, 0, 0);
    axi_read(1'b0, 12'h070, 8'd3, 2'b01, 0);

    // Concurrent read and write
    for (int i = 0; i < 4; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
    fork
      axi_write(1'b0, 12'h300, 8'd3, 2'b01, -1, 1);
      axi_read(1'b1, 12'h040, 8'd3, 2'b01, 1);
    join
    axi_read(1'b0, 12'h300, 8'd3, 2'b01, 0);

    // Reset after beat 2 of 4
    wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222;
    send_aw(1'b1, 12'h200, 8'd3, 2'b01);
    send_w(wbuf[0], 4'hF, 1'b0); model_write(12'h200, wbuf[0], 4'hF);
    send_w(wbuf[1], 4'hF, 1'b0); model_write(12'h201, wbuf[1], 4'hF);
    @(negedge clk); rst = 1; #1;
    check("midrst_bvalid", bvalid, 0); check("midrst_rvalid", rvalid, 0);
    check("midrst_wready", wready, 0); check("midrst_awready", awready, 0);
    @(negedge clk);
    check("midrst_bvalid2", bvalid, 0); check("midrst_rvalid2", rvalid, 0);
    rst = 0;
    @(negedge clk);
    check("postrst_awready", awready, 1); check("postrst_wready", wready, 0);
    axi_read(1'b1, 12'h200, 8'd1, 2'b01, 0);

    // Randomized bursts checked against the model
    for (int it = 0; it < 25; it++) begin
      idx = 12'($urandom);
      if (it % 5 == 0) idx = 12'hFFE;
      len = 8'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      burst = (r < 6) ? 2'b01 : (r < 8) ? 2'b00 : 2'b10;
      for (int i = 0; i < 8; i++) begin
        wbuf[i] = $urandom;
        sbuf[i] = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      end
      axi_write(1'($urandom), idx, len, burst,
                ($urandom_range(0, 5) == 0) ? $urandom_range(0, int'(len)) : -1,
                $urandom_range(0, 3));
      axi_read(1'($urandom), idx, len, (burst == 2'b10) ? 2'b01 : burst, 3);
      if (it % 8 == 7) axi_read(1'($urandom), idx, len, 2'b10, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_mem_slave.md
# axi_mem_slave

AXI4 memory responder: the slave end of the CPU core's AXI4 master port. It backs the CPU's instruction and data accesses with an internal word-addressed RAM in simulation and on small FPGA builds. Independent read and write state machines serve single-beat and INCR/FIXED bursts with byte strobes and ID echo.

## Interface
- C_S_AXI_ID_WIDTH, 1, AXI ID width; IDs are echoed on the response.
- C_S_AXI_ADDR_WIDTH, 32, byte address width.
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_MEM_DEPTH_LOG2, 12, log2 of RAM depth in 32-bit words (default 16 KiB).

Ports:
- CCLK  in  1  clock; all logic is on the rising edge.
- CRST  in  1  reset, synchronous, active-high.
- S_AXI_AWID/ARID  in  ID_WIDTH  request ID.
- S_AXI_AWADDR/ARADDR  in  ADDR_WIDTH  byte address; word index = addr[C_MEM_DEPTH_LOG2+1:2]. Upper bits and bits [1:0] are ignored.
- S_AXI_AWLEN/ARLEN  in  8  beats minus 1.
- S_AXI_AWSIZE/ARSIZE  in  3  ignored; always treated as 4 bytes.
- S_AXI_AWBURST/ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP (unsupported).
- S_AXI_AWVALID/ARVALID  in  1; S_AXI_AWREADY/ARREADY  out  1.
- S_AXI_WDATA  in  32; S_AXI_WSTRB  in  4  byte enables; S_AXI_WLAST  in  1; S_AXI_WVALID  in  1; S_AXI_WREADY  out  1.
- S_AXI_BID  out  ID_WIDTH; S_AXI_BRESP  out  2; S_AXI_BVALID  out  1; S_AXI_BREADY  in  1.
- S_AXI_RID  out  ID_WIDTH; S_AXI_RDATA  out  32; S_AXI_RRESP  out  2; S_AXI_RLAST  out  1; S_AXI_RVALID  out  1; S_AXI_RREADY  in  1.
- LOCK/CACHE/PROT/QOS/USER inputs on AW, AR and W: accepted and ignored. BUSER/RUSER outputs are tied to 0.

## Operation
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: AWREADY=1. On the AW handshake, latch ID, word address, LEN and BURST; clear the beat counter and error flag.
  - W_DATA: WREADY=1. On each W handshake, write the bytes whose WSTRB bit is set.
  - Address update per beat: INCR adds 1 word, wrapping modulo RAM depth. FIXED holds the address.
  - The burst ends on the beat where the counter equals AWLEN; WLAST does not terminate it.
  - WLAST=1 on any earlier beat, or WLAST=0 on the final beat, sets the error flag.
  - W_RESP: BVALID=1, BID=latched ID, BRESP=10 (SLVERR) if the error flag is set, else 00. BVALID holds until BREADY.
- WRAP write: all beats are accepted but RAM writes are suppressed, and BRESP=10.
- Read FSM: R_IDLE -> R_FETCH -> R_DATA.
  - R_IDLE: ARREADY=1. On the AR handshake, latch ID, address, LEN and BURST.
  - R_FETCH: registered RAM read.
  - R_DATA: RVALID=1, RLAST=(beat==ARLEN), RID=latched ID. RDATA, RLAST and RRESP are held stable until RREADY.
  - On the R handshake, go to R_IDLE if this was the last beat, else advance the address as for writes and go to R_FETCH.
- WRAP read: RDATA=0 and RRESP=10 on every beat; the burst length is honoured.
- Read and write channels run concurrently. A read in R_FETCH of a word written in the same cycle returns the old data.
- RAM contents are not cleared by reset and are undefined at power-up.

## Timing
- While CRST=1: AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST = 0; BRESP, RRESP, BID, RID, RDATA = 0.
- The first cycle after CRST falls: both FSMs are idle, AWREADY=1 and ARREADY=1.
- AW handshake in cycle n: WREADY=1 from n+1.
- Final W handshake in cycle m: BVALID=1 from m+1.
- After the B handshake, AWREADY=1 in the next cycle. One write and one read are outstanding at most.
- AR handshake in cycle n: first RVALID at n+2. Each following beat comes 2 cycles after the previous R handshake, so a sustained burst runs at 1 beat per 2 cycles.
- RDATA, RLAST, RRESP and RID are registered and do not change while RVALID=1 and RREADY=0.
- CRST asserted mid-burst: both FSMs return to idle on that edge and the in-flight transaction is dropped with no response. Beats already written stay in RAM.

## Test plan
- Single write: 0x10 <- 0xDEADBEEF, WSTRB=1111, AWID=1 -> BRESP=00, BID=1. Readback ARLEN=0 -> RDATA=0xDEADBEEF, RLAST=1, RRESP=00.
- INCR burst: AWLEN=3 at 0x100 with data 1,2,3,4. Read ARLEN=3 -> 1,2,3,4, RLAST only on beat 4, each RVALID 2 cycles after the previous handshake.
- Strobes: preload 0xFFFFFFFF, write 0xAAAA5555 with WSTRB=0011 -> read returns 0xFFFF5555. FIXED burst of 3 to 0x20 -> word holds the last beat.
- Backpressure: hold BREADY=0 for 5 cycles -> BVALID and BID stable, no new AWREADY. Toggle RREADY -> RDATA stable while stalled.
- Errors: WRAP write -> BRESP=10 and RAM unchanged. WRAP read -> RDATA=0, RRESP=10. WLAST on beat 1 of a 4-beat burst -> 4 beats are still accepted, BRESP=10.
- Reset mid-burst: assert CRST after beat 2 of 4 -> BVALID and RVALID are 0 during reset, AWREADY=1 the cycle after release, and beats 1-2 remain readable.
